// File: rtl/request_scheduler_if.sv
// Bus between the button/car side and request_scheduler.
// Carries the raw button levels, car position and door/arrival status in one
// direction, and the latched calls plus direction/stop decisions in the other.
interface request_scheduler_if #(
  parameter int FLOORS = 4,
  parameter int POS_W  = 2
);
  // Signalling contract: there is no valid/ready handshake on this bus.
  // Buttons, position and door_open are levels sampled on every rising clock
  // edge; arrive is a single-cycle pulse; every output is a register that the
  // consumer may sample on any rising edge.
  logic [FLOORS-1:0] btn_up;
  logic [FLOORS-1:0] btn_down;
  logic [FLOORS-1:0] btn_in;
  logic [POS_W-1:0]  position;
  logic              arrive;
  logic              door_open;
  logic [FLOORS-1:0] req_up;
  logic [FLOORS-1:0] req_down;
  logic [FLOORS-1:0] req_in;
  logic [1:0]        dir;
  logic              stop_here;
  logic              pending;

  // Button panel / car controller side
  modport master (
    output btn_up, btn_down, btn_in, position, arrive, door_open,
    input  req_up, req_down, req_in, dir, stop_here, pending
  );

  // Scheduler side
  modport slave (
    input  btn_up, btn_down, btn_in, position, arrive, door_open,
    output req_up, req_down, req_in, dir, stop_here, pending
  );
endinterface

// File: rtl/request_scheduler.sv
// request_scheduler: latches hall-up, hall-down and car calls, clears them when
// served at an open door, and runs the IDLE/UP/DOWN direction state machine.
// The dir output is the state register itself.
// Optional feature macro: REQUEST_SCHEDULER_CANCEL_EN -- a fresh press of an
// already latched car call cancels it (service at the door still wins).
module request_scheduler #(
  parameter int FLOORS = 4,
  parameter int POS_W  = 2
) (
  input  logic               clk,
  input  logic               reset,
  request_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } dir_t;

  localparam logic [POS_W:0]    FLOOR_CNT = (POS_W+1)'(FLOORS);
  // No hall-up button on the top floor, no hall-down button on the bottom floor.
  localparam logic [FLOORS-1:0] UP_OK     = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DOWN_OK   = {{(FLOORS-1){1'b1}}, 1'b0};

  logic [FLOORS-1:0] up_q, up_prev, down_q, down_prev, in_q, in_prev;
  logic [FLOORS-1:0] req_up_r, req_down_r, req_in_r;
  logic [FLOORS-1:0] req_up_n, req_down_n, req_in_n;
  logic [FLOORS-1:0] rise_up, rise_down, rise_in;
  logic [FLOORS-1:0] clr_up, clr_down, clr_in, cancel_in;
  logic [FLOORS-1:0] pos_hot, above_mask, below_mask, all_req;
  logic              pos_ok, serve;
  logic              above, below, here;
  logic              here_up, here_down, here_in;
  logic              stop_r, stop_n, pending_r;
  dir_t              dir_r, dir_n;

  // Button history: first stage samples the raw level, second holds the previous sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_q      <= '0;
      up_prev   <= '0;
      down_q    <= '0;
      down_prev <= '0;
      in_q      <= '0;
      in_prev   <= '0;
    end else begin
      up_q      <= bus.btn_up;
      up_prev   <= up_q;
      down_q    <= bus.btn_down;
      down_prev <= down_q;
      in_q      <= bus.btn_in;
      in_prev   <= in_q;
    end
  end

  // Floor decode: one-hot of the current floor and masks of floors above/below it
  always_comb begin
    pos_ok     = {1'b0, bus.position} < FLOOR_CNT;
    pos_hot    = '0;
    above_mask = '0;
    below_mask = '0;
    for (int i = 0; i < FLOORS; i++) begin
      pos_hot[i]    = pos_ok && (POS_W'(i) == bus.position);
      above_mask[i] = pos_ok && (POS_W'(i) > bus.position);
      below_mask[i] = pos_ok && (POS_W'(i) < bus.position);
    end
  end

  // Request summaries and per-floor service/set terms
  always_comb begin
    all_req   = req_up_r | req_down_r | req_in_r;
    above     = |(all_req & above_mask);
    below     = |(all_req & below_mask);
    here      = |(all_req & pos_hot);
    here_up   = |(req_up_r & pos_hot);
    here_down = |(req_down_r & pos_hot);
    here_in   = |(req_in_r & pos_hot);

    rise_up   = up_q & ~up_prev & UP_OK;
    rise_down = down_q & ~down_prev & DOWN_OK;
    rise_in   = in_q & ~in_prev;

    // Calls at an open door are served; hall calls only in the travel direction
    serve     = bus.door_open && pos_ok;
    clr_in    = serve ? pos_hot : '0;
    clr_up    = (serve && dir_r != DOWN) ? pos_hot : '0;
    clr_down  = (serve && dir_r != UP) ? pos_hot : '0;

`ifdef REQUEST_SCHEDULER_CANCEL_EN
    cancel_in = rise_in & req_in_r;
`else
    cancel_in = '0;
`endif

    // Clear is applied last so that service beats a same-cycle press
    req_up_n   = (req_up_r | rise_up) & ~clr_up;
    req_down_n = (req_down_r | rise_down) & ~clr_down;
    req_in_n   = (req_in_r | rise_in) & ~cancel_in & ~clr_in;
  end

  // Direction next-state and stop decision
  always_comb begin
    dir_n  = dir_r;
    stop_n = 1'b0;
    if (pos_ok && (bus.arrive || dir_r == IDLE)) begin
      case (dir_r)
        IDLE:    dir_n = above ? UP : (below ? DOWN : IDLE);
        UP:      dir_n = above ? UP : (below ? DOWN : IDLE);
        DOWN:    dir_n = below ? DOWN : (above ? UP : IDLE);
        default: dir_n = IDLE;
      endcase
    end
    if (pos_ok) begin
      case (dir_r)
        UP:      stop_n = here_in || here_up || (!above && here_down);
        DOWN:    stop_n = here_in || here_down || (!below && here_up);
        default: stop_n = here;
      endcase
    end
  end

  // Request latches, direction state and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_up_r   <= '0;
      req_down_r <= '0;
      req_in_r   <= '0;
      dir_r      <= IDLE;
      stop_r     <= 1'b0;
      pending_r  <= 1'b0;
    end else begin
      req_up_r   <= req_up_n;
      req_down_r <= req_down_n;
      req_in_r   <= req_in_n;
      dir_r      <= dir_n;
      stop_r     <= stop_n;
      pending_r  <= |all_req;
    end
  end

  assign bus.req_up    = req_up_r;
  assign bus.req_down  = req_down_r;
  assign bus.req_in    = req_in_r;
  assign bus.dir       = dir_r;
  assign bus.stop_here = stop_r;
  assign bus.pending   = pending_r;

endmodule
